prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/ld_checksum.sv | 29 ++
 rtl/prog_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and default sizing for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_e;

  localparam int DEF_PC_WIDTH     = 11;
  localparam int DEF_INST_WIDTH   = 9;
  localparam int DEF_START_CYCLES = 2;

endpackage

// File: rtl/ld_checksum.sv
// Running modulo-2^W sum of program words, compared against a host-supplied checksum.
module ld_checksum
  import loader_pkg::*;
#(
  parameter int INST_WIDTH = DEF_INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [INST_WIDTH-1:0] add_data,
  input  logic [INST_WIDTH-1:0] cmp_data,
  output logic [INST_WIDTH-1:0] sum,
  output logic                  match
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

  assign match = (sum == cmp_data);

endmodule

// File: rtl/prog_loader.sv
// Downloads a program from a host stream into instruction ROM, then starts the core and waits for done.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (final word is a checksum instead of a program word).
module prog_loader
  import loader_pkg::*;
#(
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int INST_WIDTH   = DEF_INST_WIDTH,
  parameter int START_CYCLES = DEF_START_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic                  in_valid,
  input  logic [INST_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [PC_WIDTH-1:0]   wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  start,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  run_done,
  output logic                  error,
  output logic [PC_WIDTH:0]     word_count
);

  localparam int CNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [PC_WIDTH-1:0] ADDR_MAX  = {PC_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]    START_END = CNT_W'(START_CYCLES - 1);

  loader_state_e state, next_state;

  logic [PC_WIDTH-1:0] addr;
  logic [PC_WIDTH:0]   count;
  logic [CNT_W-1:0]    start_cnt;
  logic                error_q;
  logic                accept;
  logic                load_go;
  logic                sum_ok;

  assign accept  = in_valid && (state == ST_LOAD);
  assign load_go = load_req &&
                   ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INST_WIDTH-1:0] cs_sum;

  // The checksum word itself is never added: wr_en excludes the in_last beat.
  ld_checksum #(
    .INST_WIDTH(INST_WIDTH)
  ) u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_go),
    .add_en   (wr_en),
    .add_data (in_data),
    .cmp_data (in_data),
    .sum      (cs_sum),
    .match    (sum_ok)
  );
`else
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_go) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          if (in_last) begin
            next_state = sum_ok ? ST_START : ST_ERROR;
          end else if (addr == ADDR_MAX) begin
            next_state = ST_ERROR;
          end
        end
      end
      ST_START: begin
        if (start_cnt == START_END) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_LOAD);
    start    = (state == ST_START);
    run_done = (state == ST_DONE);
    busy     = (state != ST_IDLE) && (state != ST_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
    wr_en    = accept && !in_last;
`else
    wr_en    = accept;
`endif
  end

  // The address saturates at the top of ROM; the overflow path leaves LOAD on that same write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      count   <= '0;
      error_q <= 1'b0;
    end else begin
      if (load_go) begin
        addr  <= '0;
        count <= '0;
      end else if (wr_en) begin
        if (addr != ADDR_MAX) addr <= addr + 1'b1;
        count <= count + 1'b1;
      end

      if (load_go) begin
        error_q <= 1'b0;
      end else if (next_state == ST_ERROR) begin
        error_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_cnt <= '0;
    end else if (state == ST_START) begin
      start_cnt <= start_cnt + 1'b1;
    end else begin
      start_cnt <= '0;
    end
  end

  assign wr_addr    = addr;
  assign wr_data    = in_data;
  assign word_count = count;
  assign error      = error_q;

endmodule
